// File: rtl/bchecc_pkg.sv
// Shared definitions for the BCH encoder controller.
//   PAR_W     : parity register width in bits
//   PAR_BYTES : parity bytes emitted per codeword (ceil(PAR_W/8))
//   LEN_W     : width of the message-length field (bytes)
//   state_t   : controller state encoding (IDLE/ENC/PAR)
//   par_byte  : selects parity byte k of the zero-padded parity register
package bchecc_pkg;

  localparam int unsigned PAR_W     = 195;
  localparam int unsigned PAR_BYTES = 25;
  localparam int unsigned LEN_W     = 11;
  localparam int unsigned K_W       = $clog2(PAR_BYTES);
  localparam int unsigned PAD_W     = PAR_BYTES * 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ENC  = 2'd1,
    ST_PAR  = 2'd2
  } state_t;

  // Byte 0 is ecc[7:0]; bits above PAR_W in the last byte read as zero.
  function automatic logic [7:0] par_byte(input logic [PAR_W-1:0] ecc,
                                          input logic [K_W-1:0]   k);
    logic [PAD_W-1:0] ext;
    ext = '0;
    ext[PAR_W-1:0] = ecc;
    ext = ext >> {k, 3'b000};
    return ext[7:0];
  endfunction

endpackage

// File: rtl/bchecc_enc_ctrl_if.sv
// Handshake/bus bundle for bchecc_enc_ctrl.
//   start_i/msg_len_i/gen_poly_i : codeword setup from the source
//   data_i/data_vld_i/data_rdy_o : message byte stream (source -> encoder)
//   par_o/par_vld_o/par_rdy_i    : parity byte stream (encoder -> sink)
//   busy_o/done_o                : status
// master = source/sink side, slave = encoder side.
interface bchecc_enc_ctrl_if;
  import bchecc_pkg::*;

  logic             start_i;
  logic [LEN_W-1:0] msg_len_i;
  logic [PAR_W-1:0] gen_poly_i;
  logic [7:0]       data_i;
  logic             data_vld_i;
  logic             data_rdy_o;
  logic [7:0]       par_o;
  logic             par_vld_o;
  logic             par_rdy_i;
  logic             busy_o;
  logic             done_o;

  modport master (
    output start_i, msg_len_i, gen_poly_i, data_i, data_vld_i, par_rdy_i,
    input  data_rdy_o, par_o, par_vld_o, busy_o, done_o
  );

  modport slave (
    input  start_i, msg_len_i, gen_poly_i, data_i, data_vld_i, par_rdy_i,
    output data_rdy_o, par_o, par_vld_o, busy_o, done_o
  );

endinterface

// File: rtl/bchecc_modgenpoly.sv
// One bit-serial step of the BCH parity LFSR (purely combinational).
//   d        : input message bit
//   r        : current parity register
//   gen_poly : generator polynomial
//   r_next   : parity register after shifting in d
module bchecc_modgenpoly #(
  parameter int unsigned PAR_W = 195
) (
  input  logic             d,
  input  logic [PAR_W-1:0] r,
  input  logic [PAR_W-1:0] gen_poly,
  output logic [PAR_W-1:0] r_next
);

  logic c;

  assign c      = d ^ r[0];
  assign r_next = ({PAR_W{c}} & gen_poly) ^ {1'b0, r[PAR_W-1:1]};

endmodule

// File: rtl/bchecc_enc_ctrl.sv
// BCH encoder controller: accepts msg_len message bytes, folds each byte
// into the parity register with eight cascaded LFSR steps in one cycle,
// then streams the PAR_BYTES parity bytes out LSB-byte first.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : bchecc_enc_ctrl_if.slave (setup, data in, parity out, status)
module bchecc_enc_ctrl (
  input  logic               clk,
  input  logic               rst_n,
  bchecc_enc_ctrl_if.slave   bus
);
  import bchecc_pkg::*;

  state_t           state_q, state_d;
  logic [PAR_W-1:0] ecc_q, ecc_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [K_W-1:0]   k_q, k_d;
  logic             done_q, done_d;

  // Byte-wide update: data_i[0] enters the chain first.
  logic [PAR_W-1:0] chain [0:8];

  assign chain[0] = ecc_q;

  for (genvar i = 0; i < 8; i++) begin : g_step
    bchecc_modgenpoly #(
      .PAR_W (PAR_W)
    ) u_step (
      .d        (bus.data_i[i]),
      .r        (chain[i]),
      .gen_poly (bus.gen_poly_i),
      .r_next   (chain[i+1])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ecc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      k_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ecc_q   <= ecc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      k_q     <= k_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ecc_d   = ecc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    k_d     = k_q;
    done_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start_i) begin
          ecc_d   = '0;
          len_d   = bus.msg_len_i;
          cnt_d   = '0;
          k_d     = '0;
          state_d = (bus.msg_len_i == '0) ? ST_PAR : ST_ENC;
        end
      end
      ST_ENC: begin
        // data_rdy_o is constant 1 here, so data_vld_i alone marks a transfer.
        if (bus.data_vld_i) begin
          ecc_d = chain[8];
          cnt_d = cnt_q + LEN_W'(1);
          if (cnt_q == len_q - LEN_W'(1)) begin
            state_d = ST_PAR;
          end
        end
      end
      ST_PAR: begin
        if (bus.par_rdy_i) begin
          if (k_q == K_W'(PAR_BYTES - 1)) begin
            k_d     = '0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            k_d = k_q + K_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.data_rdy_o = (state_q == ST_ENC);
  assign bus.par_vld_o  = (state_q == ST_PAR);
  assign bus.par_o      = (state_q == ST_PAR) ? par_byte(ecc_q, k_q) : '0;
  assign bus.busy_o     = (state_q != ST_IDLE);
  assign bus.done_o     = done_q;

endmodule
